btb_update_unit: RTL

Write side of the branch target buffer and global 2-bit predictor state.
- Owns the 256-entry BTB array and the global saturating counter.
- Accepts resolved branch/jump outcomes from the branch-resolve stage and decides mispredict flush and redirect PC.
- Updates the BTB entry and counter.
- Exposes a combinational lookup port that the fetch-stage predictor reads.

---
 rtl/btb_update_unit_pkg.sv | 42 ++++
 rtl/btb_update_unit_if.sv | 34 +++
 rtl/sat_counter2.sv | 35 +++
 rtl/btb_update_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/btb_update_unit_pkg.sv
// Shared widths, encodings and entry layout for the BTB write side and its
// direction counter.
package btb_update_unit_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned INDEX_BITS  = 8;
    localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS;
    localparam int unsigned BTB_ENTRIES = 1 << INDEX_BITS;

    localparam logic [WORD_SIZE-1:0] BTB_TARGET_INVALID = 16'hFFFF;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_INIT = WNT;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [WORD_SIZE-1:0] target;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_CLEAR = '{valid: 1'b0, tag: '0, target: BTB_TARGET_INVALID};

    function automatic logic [INDEX_BITS-1:0] pc_index(input logic [WORD_SIZE-1:0] pc);
        return pc[INDEX_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [WORD_SIZE-1:0] pc);
        return pc[WORD_SIZE-1:INDEX_BITS];
    endfunction

endpackage

// File: rtl/btb_update_unit_if.sv
// Resolve-stage inputs, fetch lookup port and flush/redirect outputs of the
// BTB update unit.
interface btb_update_unit_if;
    import btb_update_unit_pkg::*;

    logic                 resolve_valid;
    logic                 resolve_is_bj;
    logic                 resolve_taken;
    logic [WORD_SIZE-1:0] resolve_pc;
    logic [WORD_SIZE-1:0] resolve_target;
    logic [WORD_SIZE-1:0] predicted_next_pc;
    logic [WORD_SIZE-1:0] lookup_pc;
    logic                 lookup_hit;
    logic [WORD_SIZE-1:0] lookup_target;
    logic                 predict_taken;
    logic                 flush;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 init_busy;

    modport master (
        output resolve_valid, resolve_is_bj, resolve_taken, resolve_pc,
               resolve_target, predicted_next_pc, lookup_pc,
        input  lookup_hit, lookup_target, predict_taken, flush,
               redirect_pc, init_busy
    );

    modport slave (
        input  resolve_valid, resolve_is_bj, resolve_taken, resolve_pc,
               resolve_target, predicted_next_pc, lookup_pc,
        output lookup_hit, lookup_target, predict_taken, flush,
               redirect_pc, init_busy
    );

endinterface

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter with enable; holds at ST/SNT.
module sat_counter2
    import btb_update_unit_pkg::*;
#(
    parameter cnt_e INIT_VAL = CNT_INIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic up,
    output cnt_e cnt
);

    cnt_e cnt_q;
    cnt_e cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (up) begin
                if (cnt_q != ST) cnt_d = cnt_e'(2'(cnt_q + 2'd1));
            end else begin
                if (cnt_q != SNT) cnt_d = cnt_e'(2'(cnt_q - 2'd1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= INIT_VAL;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/btb_update_unit.sv
// BTB write side: clear sweep after reset, mispredict flush/redirect,
// taken-branch entry updates, global direction counter and fetch lookup.
module btb_update_unit
    import btb_update_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    btb_update_unit_if.slave   bus
);

    state_e                state_q,    state_d;
    logic [INDEX_BITS-1:0] sweep_q,    sweep_d;
    logic                  flush_q,    flush_d;
    logic [WORD_SIZE-1:0]  redirect_q, redirect_d;
    logic                  busy_q,     busy_d;

    btb_entry_t            btb_q [BTB_ENTRIES];
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    btb_entry_t            wr_entry;
    btb_entry_t            rd_entry;
    logic [WORD_SIZE-1:0]  actual_next;
    logic                  resolve_bj;
    cnt_e                  cnt;

    assign resolve_bj = bus.resolve_valid && bus.resolve_is_bj;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        wr_en       = 1'b0;
        wr_idx      = sweep_q;
        wr_entry    = BTB_ENTRY_CLEAR;
        actual_next = bus.resolve_taken ? bus.resolve_target
                                        : WORD_SIZE'(bus.resolve_pc + WORD_SIZE'(1));

        // Flush is decided in both states, independent of the instruction type.
        flush_d    = bus.resolve_valid && (actual_next != bus.predicted_next_pc);
        redirect_d = flush_d ? actual_next : redirect_q;

        unique case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                sweep_d = INDEX_BITS'(sweep_q + INDEX_BITS'(1));
                if (sweep_q == INDEX_BITS'(BTB_ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                if (resolve_bj && bus.resolve_taken) begin
                    wr_en    = 1'b1;
                    wr_idx   = pc_index(bus.resolve_pc);
                    wr_entry = '{valid: 1'b1, tag: pc_tag(bus.resolve_pc), target: bus.resolve_target};
                end
            end
            default: state_d = INIT;
        endcase

        busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            busy_q     <= busy_d;
        end
    end

    // Array has no reset; the INIT sweep establishes every entry.
    always_ff @(posedge clk) begin
        if (wr_en) btb_q[wr_idx] <= wr_entry;
    end

    sat_counter2 #(.INIT_VAL(CNT_INIT)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (resolve_bj),
        .up      (bus.resolve_taken),
        .cnt     (cnt)
    );

    // Lookup sees pre-write contents when reading the index being written.
    always_comb begin
        rd_entry          = btb_q[pc_index(bus.lookup_pc)];
        bus.lookup_hit    = (state_q == RUN) && rd_entry.valid
                            && (rd_entry.tag == pc_tag(bus.lookup_pc))
                            && (rd_entry.target != BTB_TARGET_INVALID);
        bus.lookup_target = rd_entry.target;
        bus.predict_taken = cnt[1];
    end

    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.init_busy   = busy_q;

endmodule
